conv_coeff_sched: RTL and testbench

//  Coefficient scheduler that sits in front of the 5x5 convolution core.
//  - Holds NBANKS kernels of NTAPS signed 16-bit coefficients, written through a simple config port.
//  - On every vsync it streams the selected kernel, one tap per clock, on coeff_o.
//  - Also forwards vs/hs/dv delayed by the same amount, so coefficients arrive on the core's load counter 0..NTAPS-1.

---
 rtl/conv_pkg.sv | 11 +
 rtl/coeff_bank_ram.sv | 21 ++
 rtl/conv_coeff_sched.sv | 143 ++++++++++++++
 tb/tb_conv_coeff_sched.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants, coefficient/bank types and FSM encoding for the coefficient scheduler.
package conv_pkg;
  localparam int NTAPS   = 25;
  localparam int COEFF_W = 16;
  localparam int NBANKS  = 4;
  localparam int TAP_W   = 5;

  typedef logic signed [COEFF_W-1:0]       coeff_t;
  typedef logic [$clog2(NBANKS)-1:0]       bank_t;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/coeff_bank_ram.sv
// Kernel storage: one write port, one registered read port, read-first on address collision.
// Word address is {bank, tap}; no reset so it maps onto block or distributed RAM.
module coeff_bank_ram #(
  parameter int NBANKS  = 4,
  parameter int COEFF_W = 16
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [$clog2(NBANKS)+4:0]   wr_addr,
  input  logic [COEFF_W-1:0]          wr_data,
  input  logic                        rd_en,
  input  logic [$clog2(NBANKS)+4:0]   rd_addr,
  output logic [COEFF_W-1:0]          rd_data
);
  logic [COEFF_W-1:0] mem [NBANKS*32];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/conv_coeff_sched.sv
// Streams the selected kernel one tap per clock on each vsync, aligned with 2-clk delayed timing.
// Optional kernel checksum is built only when COEFF_SUM_EN is defined.
module conv_coeff_sched #(
  parameter int NBANKS  = conv_pkg::NBANKS,
  parameter int NTAPS   = conv_pkg::NTAPS,
  parameter int COEFF_W = conv_pkg::COEFF_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [$clog2(NBANKS)-1:0]   cfg_bank,
  input  logic [4:0]                  cfg_addr,
  input  logic [COEFF_W-1:0]          cfg_data,
  input  logic                        sel_we,
  input  logic [$clog2(NBANKS)-1:0]   sel_bank,
  input  logic                        err_clr,
  input  logic                        vs_i,
  input  logic                        hs_i,
  input  logic                        dv_i,
  output logic                        vs_o,
  output logic                        hs_o,
  output logic                        dv_o,
  output logic [COEFF_W-1:0]          coeff_o,
  output logic [$clog2(NBANKS)-1:0]   active_bank_o,
  output logic                        busy_o,
  output logic                        short_err_o,
  output logic [COEFF_W+4:0]          sum_o,
  output logic                        sum_vld_o
);
  import conv_pkg::*;

  localparam int BW = $clog2(NBANKS);
  localparam logic [4:0] LAST_TAP = 5'(NTAPS - 1);

  state_t             state, state_nxt;
  logic [4:0]         tap_cnt, tap_nxt, rd_tap;
  logic [BW-1:0]      pend_bank, rd_bank;
  logic               vs_d1, hs_d1, dv_d1;
  logic               vs_rise, rd_en, rd_vld, short_set;
  logic [COEFF_W-1:0] rd_data;

  assign vs_rise = vs_i & ~vs_d1;
  assign busy_o  = (state == LOAD);

  // Tap 0 is read on the rise edge itself so the 2-clk data path matches the 2-stage timing delay.
  always_comb begin
    state_nxt = state;
    tap_nxt   = tap_cnt;
    rd_en     = 1'b0;
    rd_tap    = tap_cnt;
    rd_bank   = active_bank_o;
    short_set = 1'b0;
    case (state)
      IDLE: begin
        if (vs_rise) begin
          state_nxt = LOAD;
          tap_nxt   = '0;
          rd_en     = 1'b1;
          rd_tap    = '0;
          rd_bank   = pend_bank;
        end
      end
      LOAD: begin
        if (tap_cnt == LAST_TAP) begin
          state_nxt = HOLD;
        end else if (!vs_i) begin
          state_nxt = IDLE;
          short_set = 1'b1;
        end else begin
          tap_nxt = tap_cnt + 5'd1;
          rd_en   = 1'b1;
          rd_tap  = tap_cnt + 5'd1;
        end
      end
      HOLD: begin
        if (!vs_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      tap_cnt       <= '0;
      pend_bank     <= '0;
      active_bank_o <= '0;
      {vs_d1, hs_d1, dv_d1} <= '0;
      {vs_o, hs_o, dv_o}    <= '0;
      rd_vld        <= 1'b0;
      coeff_o       <= '0;
      short_err_o   <= 1'b0;
    end else begin
      state   <= state_nxt;
      tap_cnt <= tap_nxt;
      if (sel_we) pend_bank <= sel_bank;
      if (state == IDLE && vs_rise) active_bank_o <= pend_bank;
      {vs_d1, hs_d1, dv_d1} <= {vs_i, hs_i, dv_i};
      {vs_o, hs_o, dv_o}    <= {vs_d1, hs_d1, dv_d1};
      rd_vld <= rd_en;
      // coeff_o only follows fresh reads, so it holds the last tap between frames
      if (rd_vld) coeff_o <= rd_data;
      if (short_set)    short_err_o <= 1'b1;
      else if (err_clr) short_err_o <= 1'b0;
    end
  end

  coeff_bank_ram #(.NBANKS(NBANKS), .COEFF_W(COEFF_W)) u_ram (
    .clk     (clk),
    .wr_en   (cfg_we && (int'(cfg_addr) < NTAPS)),
    .wr_addr ({cfg_bank, cfg_addr}),
    .wr_data (cfg_data),
    .rd_en   (rd_en),
    .rd_addr ({rd_bank, rd_tap}),
    .rd_data (rd_data)
  );

`ifdef COEFF_SUM_EN
  logic signed [COEFF_W+4:0] acc;
  logic [4:0]                q_tap;
  logic                      sum_pend;

  // Accumulate alongside coeff_o; sum_o is published one cycle after the last tap is shown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      q_tap     <= '0;
      sum_pend  <= 1'b0;
      sum_o     <= '0;
      sum_vld_o <= 1'b0;
    end else begin
      if (rd_en) q_tap <= rd_tap;
      if (rd_vld) acc <= ((q_tap == 5'd0) ? '0 : acc) + $signed({{5{rd_data[COEFF_W-1]}}, rd_data});
      sum_pend  <= rd_vld && (q_tap == LAST_TAP);
      sum_vld_o <= sum_pend;
      if (sum_pend) sum_o <= acc;
    end
  end
`else
  assign sum_o     = '0;
  assign sum_vld_o = 1'b0;
`endif
endmodule

// File: tb/tb_conv_coeff_sched.sv
// Scoreboard bench: frames push expected taps/sums, a negedge monitor pops and compares.
module tb_conv_coeff_sched;
  localparam int NB = 4;
  localparam int NT = 25;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_we = 1'b0, sel_we = 1'b0, err_clr = 1'b0;
  logic [1:0]    cfg_bank = '0, sel_bank = '0;
  logic [4:0]    cfg_addr = '0;
  logic [CW-1:0] cfg_data = '0;
  logic          vs_i = 1'b0, hs_i = 1'b0, dv_i = 1'b0;
  logic          vs_o, hs_o, dv_o, busy_o, short_err_o, sum_vld_o;
  logic [CW-1:0] coeff_o;
  logic [1:0]    active_bank_o;
  logic [CW+4:0] sum_o;

  int tests = 0;
  int fails = 0;
  logic signed [CW-1:0] mem [NB][32];
  logic signed [CW-1:0] exp_q[$];
  int                   sum_q[$];
  logic [2:0]           h1, h2;
  bit                   exp_short = 1'b0;

  always #5 clk = ~clk;

  conv_coeff_sched dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_bank(cfg_bank), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .sel_we(sel_we), .sel_bank(sel_bank), .err_clr(err_clr),
    .vs_i(vs_i), .hs_i(hs_i), .dv_i(dv_i), .vs_o(vs_o), .hs_o(hs_o), .dv_o(dv_o),
    .coeff_o(coeff_o), .active_bank_o(active_bank_o), .busy_o(busy_o),
    .short_err_o(short_err_o), .sum_o(sum_o), .sum_vld_o(sum_vld_o)
  );

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sum_of(input int b);
    int s = 0;
    for (int t = 0; t < NT; t++) s += int'(mem[b][t]);
    return s;
  endfunction

  // Reference for the timing outputs: inputs two rising edges ago.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      h1 = '0;
      h2 = '0;
    end else begin
      h2 = h1;
      h1 = {vs_i, hs_i, dv_i};
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("timing_delay", 32'({vs_o, hs_o, dv_o}), 32'(h2));
      if (vs_o) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL coeff_unexpected: got %0d, expected no output", $signed(coeff_o));
        end else begin
          chk("coeff", 32'($signed(coeff_o)), 32'(exp_q.pop_front()));
        end
      end
      if (sum_vld_o) begin
        if (sum_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sum_vld_unexpected: got sum %0d, expected no strobe", $signed(sum_o));
        end else begin
          chk("sum", 32'($signed(sum_o)), sum_q.pop_front());
        end
      end
    end
  end

  task automatic wr(input int b, input int t, input logic [CW-1:0] v);
    cfg_we = 1'b1; cfg_bank = 2'(b); cfg_addr = 5'(t); cfg_data = v;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (t < NT) mem[b][t] = v;
  endtask

  task automatic sel(input int b);
    sel_we = 1'b1; sel_bank = 2'(b);
    @(posedge clk); #1;
    sel_we = 1'b0;
  endtask

  // vs_i high for hi clocks then low for 8; optional sel at the rise, cfg write at cycle wr_tap,
  // err_clr on the first low cycle.
  task automatic frame(input int hi, input int bank, input int sel_rise, input int wr_tap,
                       input logic [CW-1:0] wr_val, input bit clr_on_fall);
    int busy_cnt = 0;
    for (int c = 0; c < hi; c++) exp_q.push_back(mem[bank][(c < NT) ? c : NT-1]);
`ifdef COEFF_SUM_EN
    if (hi >= NT) sum_q.push_back(sum_of(bank));
`endif
    for (int c = 0; c < hi + 8; c++) begin
      vs_i = (c < hi);
      hs_i = (c < hi) && (c % 4 == 1);
      dv_i = (c < hi) && (c % 2 == 0);
      if (c == 0 && sel_rise >= 0) begin sel_we = 1'b1; sel_bank = 2'(sel_rise); end
      if (c == wr_tap) begin cfg_we = 1'b1; cfg_bank = 2'(bank); cfg_addr = 5'(wr_tap); cfg_data = wr_val; end
      if (c == hi && clr_on_fall) err_clr = 1'b1;
      @(posedge clk); #1;
      busy_cnt += int'(busy_o);
      sel_we = 1'b0; cfg_we = 1'b0; err_clr = 1'b0;
    end
    if (wr_tap >= 0) mem[bank][wr_tap] = wr_val;
    if (hi < NT) exp_short = 1'b1;
    chk("busy_len", busy_cnt, (hi < NT) ? hi : NT);
    chk("active_bank", 32'(active_bank_o), bank);
    chk("short_err", 32'(short_err_o), 32'(exp_short));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_coeff"}, 32'(coeff_o), 0);
    chk({tag, "_timing"}, 32'({vs_o, hs_o, dv_o}), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_short"}, 32'(short_err_o), 0);
    chk({tag, "_bank"}, 32'(active_bank_o), 0);
    chk({tag, "_sum"}, 32'(sum_o), 0);
    chk({tag, "_sum_vld"}, 32'(sum_vld_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk_zero("reset");
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    // bank0: k, bank1: 0x0100, bank2: -3k (sum -900); one out-of-range write must be dropped
    for (int t = 0; t < NT; t++) begin
      wr(0, t, 16'(t));
      wr(1, t, 16'h0100);
      wr(2, t, 16'(-3 * t));
    end
    wr(0, 27, 16'h7777);

    // 1: full frame, holds tap 24 to the end, sum 300
    frame(40, 0, -1, -1, '0, 1'b0);
    // 2: 0x0100 x25, sum 0x1900
    sel(1);
    frame(30, 1, -1, -1, '0, 1'b0);
    // 3: select on the rise edge only affects the following frame
    frame(30, 1, 2, -1, '0, 1'b0);
    frame(30, 2, -1, -1, '0, 1'b0);
    // 4: short frame, sticky error, clear, then set-wins-over-clear
    sel(0);
    frame(10, 0, -1, -1, '0, 1'b0);
    repeat (5) @(posedge clk);
    #1 chk("short_sticky", 32'(short_err_o), 1);
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0; exp_short = 1'b0;
    chk("short_cleared", 32'(short_err_o), 0);
    frame(10, 0, -1, -1, '0, 1'b1);
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0; exp_short = 1'b0;
    chk("short_cleared2", 32'(short_err_o), 0);
    // 5: write tap 5 while it is read: old value now, 0xFF00 next frame (sum 300-5-256 = 39)
    frame(30, 0, -1, 5, 16'hFF00, 1'b0);
    frame(30, 0, -1, -1, '0, 1'b0);
    chk("sum_model_bank0", sum_of(0), 39);

    // 6: reset while streaming; taps 0..10 are visible before it hits
    sel(2);
    for (int c = 0; c < 11; c++) exp_q.push_back(mem[2][c]);
    for (int c = 0; c < 13; c++) begin
      vs_i = 1'b1; hs_i = 1'b0; dv_i = 1'b1;
      @(posedge clk); #1;
    end
    #1 rst = 1'b0;
    #1 chk_zero("midreset");
    vs_i = 1'b0; dv_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 frame(30, 0, -1, -1, '0, 1'b0);

    chk("coeff_queue_drained", exp_q.size(), 0);
    chk("sum_queue_drained", sum_q.size(), 0);
`ifndef COEFF_SUM_EN
    chk("sum_disabled", 32'(sum_o), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
